// File: rtl/egress_pop_pacer.sv
// Paces root pops against buffer space/credit, buffers popped entries and sends each for max(L,1) beats.
// Optional statistics outputs are enabled with `define EGRESS_PACER_STATS_EN.
module egress_pop_pacer #(
    parameter int PTW      = 16,
    parameter int MTW      = 2,
    parameter int PLW      = 4,
    parameter int TREE_NUM = 4,
    parameter int DEPTH    = 4,
    parameter int MAX_OUT  = 2,
    parameter int TIMEOUT  = 64,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int DW            = MTW + PTW + PLW,
    localparam int OW            = $clog2(MAX_OUT + 1),
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_enable,
    input  logic                     i_task_fifo_full,
    output logic                     o_pop,
    input  logic                     i_pop_out,
    input  logic [TREE_NUM_BITS-1:0] i_pop_tree_id,
    input  logic [DW-1:0]            i_pop_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic [DW-1:0]            o_tx_data,
    output logic [TREE_NUM_BITS-1:0] o_tx_tree_id,
    output logic                     o_tx_sop,
    output logic                     o_tx_eop,
    output logic [OW-1:0]            o_outstanding,
    output logic [CW-1:0]            o_fifo_count,
    output logic                     o_timeout,
`ifdef EGRESS_PACER_STATS_EN
    output logic [31:0]              o_stat_pkts,
    output logic [31:0]              o_stat_beats,
    output logic [15:0]              o_stat_empty,
`endif
    output logic                     o_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = TREE_NUM_BITS + DW;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [EW-1:0]            mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OW-1:0]            out_q, out_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic                     pop_q, pop_d;
    logic                     err_q, err_d;
    logic [0:0]               state_q, state_d;
    logic [DW-1:0]            tx_dat_q, tx_dat_d;
    logic [TREE_NUM_BITS-1:0] tx_tree_q, tx_tree_d;
    logic [PLW-1:0]           beats_q, beats_d;
    logic                     sop_q, sop_d;

    logic                     rsp_ones, fifo_full, fifo_wr, fifo_rd;
    logic                     tx_hs, tx_last, tmo_fire;
    logic [EW-1:0]            head;
    logic [PLW-1:0]           head_len;

    assign head     = mem_q[rd_ptr_q];
    assign head_len = head[PTW+PLW-1:PTW];

    assign rsp_ones  = &i_pop_data;
    assign fifo_full = (cnt_q == CW'(DEPTH));
    assign fifo_wr   = i_pop_out && !rsp_ones && !fifo_full;

    assign tx_hs    = (state_q == ST_SEND) && i_tx_ready;
    assign tx_last  = tx_hs && (beats_q == PLW'(1));
    // Reload on the eop handshake so back-to-back packets have no idle beat.
    assign fifo_rd  = (cnt_q != '0) && ((state_q == ST_IDLE) || tx_last);

    assign tmo_fire = (out_q != '0) && !i_pop_out && !pop_q && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        pop_d = i_enable && !i_task_fifo_full && (int'(out_q) < MAX_OUT)
                && ((int'(cnt_q) + int'(out_q)) < DEPTH);

        out_d = out_q;
        if (pop_d) begin
            out_d = out_d + OW'(1);
        end
        if ((i_pop_out && (out_q != '0)) || tmo_fire) begin
            out_d = out_d - OW'(1);
        end

        tmo_d = tmo_q + TW'(1);
        if (i_pop_out || pop_q || (out_q == '0) || tmo_fire) begin
            tmo_d = '0;
        end

        err_d = err_q || (i_pop_out && (fifo_full || (out_q == '0)));
        cnt_d = cnt_q + CW'(fifo_wr) - CW'(fifo_rd);
    end

    always_comb begin
        state_d   = state_q;
        tx_dat_d  = tx_dat_q;
        tx_tree_d = tx_tree_q;
        beats_d   = beats_q;
        sop_d     = sop_q;
        if (fifo_rd) begin
            state_d   = ST_SEND;
            tx_dat_d  = head[DW-1:0];
            tx_tree_d = head[EW-1:DW];
            beats_d   = (head_len == '0) ? PLW'(1) : head_len;
            sop_d     = 1'b1;
        end else if (tx_hs) begin
            beats_d = beats_q - PLW'(1);
            sop_d   = 1'b0;
            if (beats_q == PLW'(1)) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            tmo_q     <= '0;
            pop_q     <= 1'b0;
            err_q     <= 1'b0;
            state_q   <= ST_IDLE;
            tx_dat_q  <= '0;
            tx_tree_q <= '0;
            beats_q   <= '0;
            sop_q     <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            tmo_q     <= tmo_d;
            pop_q     <= pop_d;
            err_q     <= err_d;
            state_q   <= state_d;
            tx_dat_q  <= tx_dat_d;
            tx_tree_q <= tx_tree_d;
            beats_q   <= beats_d;
            sop_q     <= sop_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= {i_pop_tree_id, i_pop_data};
        end
    end

`ifdef EGRESS_PACER_STATS_EN
    logic [31:0] stat_pkts_q, stat_beats_q;
    logic [15:0] stat_empty_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stat_pkts_q  <= '0;
            stat_beats_q <= '0;
            stat_empty_q <= '0;
        end else begin
            if (tx_last) begin
                stat_pkts_q <= stat_pkts_q + 32'd1;
            end
            if (tx_hs) begin
                stat_beats_q <= stat_beats_q + 32'd1;
            end
            if (i_pop_out && rsp_ones) begin
                stat_empty_q <= stat_empty_q + 16'd1;
            end
        end
    end

    assign o_stat_pkts  = stat_pkts_q;
    assign o_stat_beats = stat_beats_q;
    assign o_stat_empty = stat_empty_q;
`endif

    assign o_pop         = pop_q;
    assign o_tx_valid    = (state_q == ST_SEND);
    assign o_tx_data     = tx_dat_q;
    assign o_tx_tree_id  = tx_tree_q;
    assign o_tx_sop      = (state_q == ST_SEND) && sop_q;
    assign o_tx_eop      = (state_q == ST_SEND) && (beats_q == PLW'(1));
    assign o_outstanding = out_q;
    assign o_fifo_count  = cnt_q;
    assign o_timeout     = tmo_fire;
    assign o_err         = err_q;

endmodule
